// File: rtl/psram_opi_resp_pkg.sv
// Shared definitions for the OPI PSRAM register-space responder:
// FSM encoding, default opcodes, ID constants and the read-latency helper.
package psram_opi_resp_pkg;

    typedef enum logic [2:0] {
        PSRAM_RESP_IDLE,
        PSRAM_RESP_CMD,
        PSRAM_RESP_ADDR,
        PSRAM_RESP_WDATA,
        PSRAM_RESP_LAT,
        PSRAM_RESP_RDATA,
        PSRAM_RESP_IGNORE
    } psram_resp_state_e;

    localparam logic [7:0] PSRAM_RESP_CMD_MRW   = 8'hC0;
    localparam logic [7:0] PSRAM_RESP_CMD_MRR   = 8'h40;
    localparam logic [7:0] PSRAM_RESP_VENDOR_ID = 8'h0D;
    localparam logic [7:0] PSRAM_RESP_DEVICE_ID = 8'h8D;
    localparam logic [3:0] PSRAM_RESP_CNT_MAX   = 4'hF;

    // Latency in SCK edges: two edges per clock of the MR0[5:3] code plus 3.
    function automatic logic [4:0] psram_resp_lat_edges(input logic [2:0] code);
        return {({1'b0, code} + 4'd3), 1'b0};
    endfunction

endpackage

// File: rtl/psram_opi_resp_edge_det.sv
// Input synchroniser for the responder: registers sck/ce/dq once and
// flags each SCK transition (both edges, DDR) in the cycle it is seen.
module psram_resp_edge_det (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sck_i,
    input  logic       ce_i,
    input  logic [7:0] dq_i,
    output logic       edge_o,
    output logic       ce_low_o,
    output logic [7:0] byte_o
);

    logic       sck_q;
    logic       sck_prev;
    logic       ce_q;
    logic [7:0] dq_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_q    <= 1'b0;
            sck_prev <= 1'b0;
            ce_q     <= 1'b1;
            dq_q     <= 8'h00;
        end else begin
            sck_q    <= sck_i;
            sck_prev <= sck_q;
            ce_q     <= ce_i;
            dq_q     <= dq_i;
        end
    end

    assign edge_o   = sck_q != sck_prev;
    assign ce_low_o = ~ce_q;
    assign byte_o   = dq_q;

endmodule

// File: rtl/psram_opi_resp.sv
// OPI PSRAM mode-register responder: decodes DDR MRW/MRR frames and drives
// DQ/DQS back after the MR0-programmed latency. Option: PSRAM_RESP_ID_REG_EN.
//
// state  | meaning
// IDLE   | CE high, waiting for a frame
// CMD    | capturing the two command bytes
// ADDR   | four address bytes, MA taken from the last one
// WDATA  | waiting for the MRW data byte
// LAT    | counting read-latency edges
// RDATA  | driving MR[MA] on DQ with a toggling DQS
// IGNORE | frame finished or rejected, waiting for CE high
module psram_opi_resp
    import psram_opi_resp_pkg::*;
#(
    parameter int         MR_NUM  = 8,
    parameter logic [7:0] CMD_MRW = PSRAM_RESP_CMD_MRW,
    parameter logic [7:0] CMD_MRR = PSRAM_RESP_CMD_MRR
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       psram_sck_i,
    input  logic       psram_ce_i,
    input  logic [7:0] psram_io_in_i,
    output logic [7:0] psram_io_out_o,
    output logic [7:0] psram_io_en_o,
    output logic       psram_dqs_out_o,
    output logic       psram_dqs_en_o,
    output logic       wr_done_o,
    output logic       err_o
);

    localparam int         MA_W     = (MR_NUM > 1) ? $clog2(MR_NUM) : 1;
    localparam logic [7:0] MR_LIMIT = 8'(MR_NUM);

    logic       sck_edge;
    logic       ce_low;
    logic [7:0] rx_byte;

    psram_resp_edge_det u_edge_det (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sck_i    (psram_sck_i),
        .ce_i     (psram_ce_i),
        .dq_i     (psram_io_in_i),
        .edge_o   (sck_edge),
        .ce_low_o (ce_low),
        .byte_o   (rx_byte)
    );

    psram_resp_state_e state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] cmd0, cmd0_n;
    logic       is_wr, is_wr_n;
    logic [7:0] ma, ma_n;
    logic       dqs, dqs_n;
    logic       wr_done_n, err_n;
    logic       mr_we;
    logic [7:0] mr [MR_NUM];
    logic [7:0] mr_rd;
    logic [4:0] lat;
    logic       lat_done;
    logic       ma_ok;
    logic       ma_wr_ok;

    assign ma_ok = ma < MR_LIMIT;
`ifdef PSRAM_RESP_ID_REG_EN
    assign ma_wr_ok = ma_ok && (ma != 8'd1) && (ma != 8'd2);
`else
    assign ma_wr_ok = ma_ok;
`endif

    always_comb begin
        mr_rd = 8'h00;
        if (ma_ok) begin
            mr_rd = mr[ma[MA_W-1:0]];
        end
`ifdef PSRAM_RESP_ID_REG_EN
        if (ma == 8'd1) begin
            mr_rd = PSRAM_RESP_VENDOR_ID;
        end
        if (ma == 8'd2) begin
            mr_rd = PSRAM_RESP_DEVICE_ID;
        end
`endif
    end

    // Codes above 5 exceed what the saturating counter can reach; they clamp to 16 edges.
    assign lat      = psram_resp_lat_edges(mr[0][5:3]);
    assign lat_done = ({1'b0, cnt} == (lat - 5'd1)) || (cnt == PSRAM_RESP_CNT_MAX);

    always_comb begin
        state_n   = state;
        cmd0_n    = cmd0;
        is_wr_n   = is_wr;
        ma_n      = ma;
        dqs_n     = 1'b0;
        wr_done_n = 1'b0;
        err_n     = 1'b0;
        mr_we     = 1'b0;
        if (!ce_low) begin
            state_n = PSRAM_RESP_IDLE;
        end else begin
            case (state)
                PSRAM_RESP_IDLE: state_n = PSRAM_RESP_CMD;
                PSRAM_RESP_CMD: begin
                    if (sck_edge) begin
                        if (cnt == 4'd0) begin
                            cmd0_n = rx_byte;
                        end else if (rx_byte != cmd0 ||
                                     (rx_byte != CMD_MRW && rx_byte != CMD_MRR)) begin
                            state_n = PSRAM_RESP_IGNORE;
                            err_n   = 1'b1;
                        end else begin
                            is_wr_n = rx_byte == CMD_MRW;
                            state_n = PSRAM_RESP_ADDR;
                        end
                    end
                end
                PSRAM_RESP_ADDR: begin
                    if (sck_edge && cnt == 4'd3) begin
                        ma_n    = rx_byte;
                        state_n = is_wr ? PSRAM_RESP_WDATA : PSRAM_RESP_LAT;
                    end
                end
                PSRAM_RESP_WDATA: begin
                    if (sck_edge) begin
                        state_n = PSRAM_RESP_IGNORE;
                        if (ma_ok) begin
                            mr_we     = ma_wr_ok;
                            wr_done_n = 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                PSRAM_RESP_LAT: begin
                    if (sck_edge && lat_done) begin
                        state_n = PSRAM_RESP_RDATA;
                    end
                end
                PSRAM_RESP_RDATA: dqs_n = sck_edge ? ~dqs : dqs;
                PSRAM_RESP_IGNORE: state_n = PSRAM_RESP_IGNORE;
                default: state_n = PSRAM_RESP_IDLE;
            endcase
        end
        if (state_n != state) begin
            cnt_n = 4'd0;
        end else if (sck_edge && cnt != PSRAM_RESP_CNT_MAX) begin
            cnt_n = cnt + 4'd1;
        end else begin
            cnt_n = cnt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= PSRAM_RESP_IDLE;
            cnt       <= 4'd0;
            cmd0      <= 8'h00;
            is_wr     <= 1'b0;
            ma        <= 8'h00;
            dqs       <= 1'b0;
            wr_done_o <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cmd0      <= cmd0_n;
            is_wr     <= is_wr_n;
            ma        <= ma_n;
            dqs       <= dqs_n;
            wr_done_o <= wr_done_n;
            err_o     <= err_n;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MR_NUM; i++) begin
                mr[i] <= 8'h00;
            end
        end else if (mr_we) begin
            mr[ma[MA_W-1:0]] <= rx_byte;
        end
    end

    assign psram_io_out_o  = (state == PSRAM_RESP_RDATA) ? mr_rd : 8'h00;
    assign psram_io_en_o   = (state == PSRAM_RESP_RDATA) ? 8'hFF : 8'h00;
    assign psram_dqs_en_o  = state == PSRAM_RESP_RDATA;
    assign psram_dqs_out_o = dqs;

endmodule

// File: tb/tb_psram_opi_resp.sv
// Directed plus randomized frames against a mode-register model of the responder.
module tb_psram_opi_resp;
    import psram_opi_resp_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       ce  = 1'b1;
    logic [7:0] dq  = 8'h00;
    logic [7:0] io_out, io_en;
    logic       dqs_out, dqs_en, wr_done, err;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mr_m [8];

    always #5 clk = ~clk;

    psram_opi_resp dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .psram_sck_i     (sck),
        .psram_ce_i      (ce),
        .psram_io_in_i   (dq),
        .psram_io_out_o  (io_out),
        .psram_io_en_o   (io_en),
        .psram_dqs_out_o (dqs_out),
        .psram_dqs_en_o  (dqs_en),
        .wr_done_o       (wr_done),
        .err_o           (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] ma);
        if (ma >= 8) return 8'h00;
`ifdef PSRAM_RESP_ID_REG_EN
        if (ma == 8'd1) return 8'h0D;
        if (ma == 8'd2) return 8'h8D;
`endif
        return mr_m[ma[2:0]];
    endfunction

    function automatic void m_write(input logic [7:0] ma, input logic [7:0] d);
        if (ma >= 8) return;
`ifdef PSRAM_RESP_ID_REG_EN
        if (ma == 8'd1 || ma == 8'd2) return;
`endif
        mr_m[ma[2:0]] = d;
    endfunction

    function automatic int m_lat();
        return 2 * (int'(mr_m[0][5:3]) + 3);
    endfunction

    // One DDR byte; returns once the responder has reacted to the edge.
    task automatic edge_tx(input logic [7:0] b);
        @(negedge clk) dq = b;
        @(negedge clk) sck = ~sck;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic ce_start();
        @(negedge clk) ce = 1'b0;
        @(negedge clk);
    endtask

    task automatic ce_stop();
        @(negedge clk) ce = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_enables", {23'd0, dqs_en, io_en}, 32'd0);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [7:0] ma);
        edge_tx(op);
        edge_tx(op);
        edge_tx(8'($urandom));
        edge_tx(8'($urandom));
        edge_tx(8'($urandom));
        edge_tx(ma);
    endtask

    task automatic mrw(input logic [7:0] ma, input logic [7:0] d);
        ce_start();
        send_hdr(8'hC0, ma);
        chk("mrw_no_drive", {24'd0, io_en}, 32'd0);
        edge_tx(d);
        if (ma < 8) chk("mrw_wr_done", {31'd0, wr_done}, 32'd1);
        else        chk("mrw_err", {31'd0, err}, 32'd1);
        @(negedge clk);
        chk("mrw_pulse_end", {30'd0, wr_done, err}, 32'd0);
        ce_stop();
        m_write(ma, d);
    endtask

    task automatic mrr(input logic [7:0] ma, input int n);
        int L;
        logic [7:0] exp;
        L   = m_lat();
        exp = m_read(ma);
        ce_start();
        send_hdr(8'h40, ma);
        for (int i = 1; i <= L; i++) begin
            edge_tx(8'($urandom));
            if (i < L) begin
                chk("lat_en_low", {23'd0, dqs_en, io_en}, 32'd0);
            end else begin
                chk("rd_en", {23'd0, dqs_en, io_en}, {23'd0, 9'h1FF});
                chk("rd_dqs_entry", {31'd0, dqs_out}, 32'd0);
                chk("rd_data", {24'd0, io_out}, {24'd0, exp});
            end
        end
        for (int k = 1; k <= n; k++) begin
            edge_tx(8'($urandom));
            chk("rd_data_rep", {24'd0, io_out}, {24'd0, exp});
            chk("rd_dqs_toggle", {31'd0, dqs_out}, 32'(k % 2));
        end
        ce_stop();
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] ma;
        int wr_before;
        for (int i = 0; i < 8; i++) mr_m[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_outputs", {12'd0, io_out, io_en, dqs_out, dqs_en, wr_done, err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        mrr(8'd0, 3);
        mrw(8'd4, 8'hA5);
        mrr(8'd4, 2);
        mrw(8'd0, 8'h10);
        chk("lat_code2", 32'(m_lat()), 32'd10);
        mrr(8'd4, 2);

        // mismatched and unknown command bytes
        ce_start();
        edge_tx(8'hC0);
        edge_tx(8'h40);
        chk("mismatch_err", {31'd0, err}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            edge_tx(8'($urandom));
            chk("mismatch_no_drive", {23'd0, dqs_en, io_en}, 32'd0);
        end
        ce_stop();
        ce_start();
        edge_tx(8'h12);
        edge_tx(8'h12);
        chk("unknown_op_err", {31'd0, err}, 32'd1);
        ce_stop();
        mrw(8'd3, 8'h5A);

        // CE rises after A1 of an MRW
        ce_start();
        edge_tx(8'hC0);
        edge_tx(8'hC0);
        edge_tx(8'h00);
        edge_tx(8'h00);
        edge_tx(8'h00);
        wr_before = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) if (i == 0) ce = 1'b1;
            if (wr_done) wr_before++;
        end
        chk("abort_no_wr_done", 32'(wr_before), 32'd0);
        chk("abort_idle", {29'd0, dut.state}, {29'd0, PSRAM_RESP_IDLE});
        mrr(8'd3, 1);

        mrw(8'd1, 8'hFF);
        mrr(8'd1, 1);
        mrr(8'd9, 1);

        for (int t = 0; t < 25; t++) begin
            ma = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                if (ma == 8'd0) d[5:3] = 3'($urandom_range(0, 4));
                mrw(ma, d);
            end else begin
                mrr(ma, $urandom_range(1, 4));
            end
        end

        // reset in the middle of a read restores all registers
        mrw(8'd5, 8'h3C);
        ce_start();
        send_hdr(8'h40, 8'd5);
        edge_tx(8'h00);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("midframe_rst", {12'd0, io_out, io_en, dqs_out, dqs_en, wr_done, err}, 32'd0);
        ce = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 8; i++) mr_m[i] = 8'h00;
        repeat (2) @(negedge clk);
        mrr(8'd5, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
